// File: rtl/tree_path_resolver_if.sv
// Bundle of the three resolver channels: identifier beats in, tree-memory
// read port out, and the resolved result out. "slave" is the resolver side,
// "master" is the surrounding environment (parser, memory, consumer).
interface tree_path_resolver_if #(
  parameter int IDENTIFIER_SIZE     = 8,
  parameter int NODE_ADDR_SIZE      = 8,
  parameter int MAX_NODES_PER_LEVEL = 4,
  parameter int NUM_MSG_HIERARCHY   = 4
);
  localparam int NODE_SIZE = IDENTIFIER_SIZE + NODE_ADDR_SIZE*(MAX_NODES_PER_LEVEL+1);
  localparam int DEPTH_W   = $clog2(NUM_MSG_HIERARCHY+1);

  logic                       id_valid;
  logic                       id_ready;
  logic [IDENTIFIER_SIZE-1:0] id_data;
  logic                       id_last;

  logic                       mem_rd_en;
  logic [NODE_ADDR_SIZE-1:0]  mem_rd_addr;
  logic [NODE_SIZE-1:0]       mem_rd_data;

  logic                       res_valid;
  logic                       res_ready;
  logic [NODE_ADDR_SIZE-1:0]  res_addr;
  logic                       res_found;
  logic [DEPTH_W-1:0]         res_depth;

  modport master (
    output id_valid, id_data, id_last, mem_rd_data, res_ready,
    input  id_ready, mem_rd_en, mem_rd_addr, res_valid, res_addr, res_found, res_depth
  );

  modport slave (
    input  id_valid, id_data, id_last, mem_rd_data, res_ready,
    output id_ready, mem_rd_en, mem_rd_addr, res_valid, res_addr, res_found, res_depth
  );
endinterface

// File: rtl/tree_path_resolver.sv
// Walks the builder's tree memory from the root, one hierarchy level per
// identifier beat, and reports the deepest matched node, a found flag and
// the matched depth. Read-only user of a single synchronous read port.
module tree_path_resolver #(
  parameter int IDENTIFIER_SIZE     = 8,
  parameter int NODE_ADDR_SIZE      = 8,
  parameter int MAX_NODES_PER_LEVEL = 4,
  parameter int NUM_MSG_HIERARCHY   = 4
) (
  input logic                clk,
  input logic                rst_n,
  tree_path_resolver_if.slave bus
);
  localparam int NODE_SIZE = IDENTIFIER_SIZE + NODE_ADDR_SIZE*(MAX_NODES_PER_LEVEL+1);
  localparam int DEPTH_W   = $clog2(NUM_MSG_HIERARCHY+1);
  localparam int SLOT_W    = (MAX_NODES_PER_LEVEL > 1) ? $clog2(MAX_NODES_PER_LEVEL) : 1;
  localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'(NUM_MSG_HIERARCHY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARENT,
    S_PROBE,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t                     r_state;
  logic                       r_id_ready;
  logic                       r_res_valid;
  logic                       r_res_found;
  logic [IDENTIFIER_SIZE-1:0] r_id;
  logic                       r_last;
  logic [NODE_ADDR_SIZE-1:0]  r_cur_addr;
  logic [DEPTH_W-1:0]         r_depth;
  logic [SLOT_W-1:0]          r_slot;
  logic [NODE_ADDR_SIZE-1:0]  r_child [MAX_NODES_PER_LEVEL];

  logic [NODE_ADDR_SIZE-1:0]  w_mem_child [MAX_NODES_PER_LEVEL];
  logic [IDENTIFIER_SIZE-1:0] w_mem_id;
  logic                       w_unused_parent;
  logic [SLOT_W-1:0]          w_next_slot;
  logic                       w_has_next;
  logic                       w_match;
  logic                       w_accept;
  logic                       w_at_max;
  logic                       w_rd_en;
  logic [NODE_ADDR_SIZE-1:0]  w_rd_addr;

  // Split the node word into its child slots and identifier.
  always_comb begin
    for (int unsigned k = 0; k < MAX_NODES_PER_LEVEL; k++) begin
      w_mem_child[k] = bus.mem_rd_data[k*NODE_ADDR_SIZE +: NODE_ADDR_SIZE];
    end
    w_mem_id = bus.mem_rd_data[NODE_SIZE-1 -: IDENTIFIER_SIZE];
  end

  // Parent pointer is not needed for a top-down walk.
  assign w_unused_parent = ^bus.mem_rd_data[MAX_NODES_PER_LEVEL*NODE_ADDR_SIZE +: NODE_ADDR_SIZE];

  assign w_next_slot = r_slot + SLOT_W'(1);
  assign w_has_next  = ((int'(r_slot) + 1) < MAX_NODES_PER_LEVEL) && (r_child[w_next_slot] != '0);
  // Identifier 0 never names a real node, so it can never match.
  assign w_match     = (w_mem_id == r_id) && (r_id != '0);
  assign w_accept    = r_id_ready && bus.id_valid;
  assign w_at_max    = (r_depth == MAX_DEPTH);

  // Read strobe/address are decoded from the registered state so that the
  // node word for the next probe lands exactly one cycle after the decision;
  // a registered strobe would add a cycle per level.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = r_cur_addr;
    case (r_state)
      S_IDLE: begin
        w_rd_en = w_accept && !w_at_max;
      end
      S_PARENT: begin
        w_rd_addr = w_mem_child[0];
        w_rd_en   = (w_mem_child[0] != '0);
      end
      S_PROBE: begin
        w_rd_addr = r_child[w_next_slot];
        w_rd_en   = !w_match && w_has_next;
      end
      default: begin
        w_rd_en = 1'b0;
      end
    endcase
  end

  // Walk controller: accepts beats, scans child slots, drains, responds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_id_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_found <= 1'b0;
      r_id        <= '0;
      r_last      <= 1'b0;
      r_cur_addr  <= '0;
      r_depth     <= '0;
      r_slot      <= '0;
      for (int unsigned k = 0; k < MAX_NODES_PER_LEVEL; k++) begin
        r_child[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id   <= bus.id_data;
            r_last <= bus.id_last;
            if (!w_at_max) begin
              r_id_ready <= 1'b0;
              r_state    <= S_PARENT;
            end else if (bus.id_last) begin
              r_id_ready  <= 1'b0;
              r_res_valid <= 1'b1;
              r_res_found <= 1'b0;
              r_state     <= S_RESP;
            end else begin
              r_id_ready <= 1'b1;
              r_state    <= S_DRAIN;
            end
          end else begin
            r_id_ready <= 1'b1;
          end
        end

        S_PARENT: begin
          for (int unsigned k = 0; k < MAX_NODES_PER_LEVEL; k++) begin
            r_child[k] <= w_mem_child[k];
          end
          r_slot <= '0;
          if (w_mem_child[0] != '0) begin
            r_state <= S_PROBE;
          end else if (r_last) begin
            r_res_valid <= 1'b1;
            r_res_found <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_id_ready <= 1'b1;
            r_state    <= S_DRAIN;
          end
        end

        S_PROBE: begin
          if (w_match) begin
            r_cur_addr <= r_child[r_slot];
            r_depth    <= r_depth + DEPTH_W'(1);
            if (r_last) begin
              r_res_valid <= 1'b1;
              r_res_found <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_id_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else if (w_has_next) begin
            r_slot <= w_next_slot;
          end else if (r_last) begin
            r_res_valid <= 1'b1;
            r_res_found <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_id_ready <= 1'b1;
            r_state    <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (w_accept && bus.id_last) begin
            r_id_ready  <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_found <= 1'b0;
            r_state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_res_found <= 1'b0;
            r_cur_addr  <= '0;
            r_depth     <= '0;
            r_id_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.id_ready    = r_id_ready;
  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_rd_addr = w_rd_addr;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_addr    = r_cur_addr;
  assign bus.res_found   = r_res_found;
  assign bus.res_depth   = r_depth;
endmodule

// File: tb/tb_tree_path_resolver.sv
// Bench for tree_path_resolver: a tree held as plain arrays drives both a
// synchronous memory model and a path-walking reference; results are
// scoreboarded by an independent monitor, plus directed timing checks.
module tb_tree_path_resolver;
  localparam int IW   = 8;
  localparam int AW   = 8;
  localparam int MAXN = 4;
  localparam int NUM  = 4;
  localparam int NS   = IW + AW*(MAXN+1);
  localparam int DW   = $clog2(NUM+1);

  typedef struct {
    int addr;
    int found;
    int depth;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tree_path_resolver_if #(
    .IDENTIFIER_SIZE(IW), .NODE_ADDR_SIZE(AW),
    .MAX_NODES_PER_LEVEL(MAXN), .NUM_MSG_HIERARCHY(NUM)
  ) bus ();

  tree_path_resolver #(
    .IDENTIFIER_SIZE(IW), .NODE_ADDR_SIZE(AW),
    .MAX_NODES_PER_LEVEL(MAXN), .NUM_MSG_HIERARCHY(NUM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Tree held as plain arrays
  int node_id [256];
  int par     [256];
  int kids    [256][MAXN];
  int nkids   [256];

  logic [NS-1:0] mem [256];
  logic [NS-1:0] rd_q;
  int            rd_cnt = 0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_rd_en) begin
      rd_q   <= mem[bus.mem_rd_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end
  assign bus.mem_rd_data = rd_q;

  int   total = 0;
  int   bad = 0;
  res_t exp_q[$];
  int   path_buf[8];
  int   acc_cyc[8];
  int   rr_mode = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] outs();
    return {9'd0, bus.id_ready, bus.mem_rd_en, bus.mem_rd_addr, bus.res_valid,
            bus.res_addr, bus.res_found, bus.res_depth};
  endfunction

  function automatic void clear_tree();
    for (int a = 0; a < 256; a++) begin
      node_id[a] = 0;
      par[a]     = 0;
      nkids[a]   = 0;
      for (int s = 0; s < MAXN; s++) kids[a][s] = 0;
    end
  endfunction

  function automatic void add_node(int idx, int id, int parent);
    node_id[idx] = id;
    par[idx]     = parent;
    kids[parent][nkids[parent]] = idx;
    nkids[parent]++;
  endfunction

  function automatic void load_mem();
    logic [NS-1:0] w;
    for (int a = 0; a < 256; a++) begin
      w = '0;
      for (int s = 0; s < MAXN; s++) w[s*AW +: AW] = AW'(kids[a][s]);
      w[MAXN*AW +: AW] = AW'(par[a]);
      w[NS-1 -: IW]    = IW'(node_id[a]);
      mem[a] = w;
    end
  endfunction

  // Reference: follow the path from the root, first matching child wins,
  // stop matching at the first miss or when the hierarchy is exhausted.
  function automatic res_t ref_walk(int len);
    res_t r;
    int   hit;
    r.addr = 0; r.found = 1; r.depth = 0;
    for (int i = 0; i < len; i++) begin
      if (r.found == 0) continue;
      if (r.depth == NUM) begin
        r.found = 0;
        continue;
      end
      hit = -1;
      for (int s = 0; s < nkids[r.addr]; s++) begin
        if (path_buf[i] != 0 && node_id[kids[r.addr][s]] == path_buf[i]) begin
          hit = kids[r.addr][s];
          break;
        end
      end
      if (hit < 0) r.found = 0;
      else begin
        r.addr = hit;
        r.depth++;
      end
    end
    return r;
  endfunction

  task automatic send_path(input int len);
    int t;
    exp_q.push_back(ref_walk(len));
    for (int i = 0; i < len; i++) begin
      bus.id_valid = 1'b1;
      bus.id_data  = IW'(path_buf[i]);
      bus.id_last  = (i == len-1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.id_ready && t < 200);
      if (!bus.id_ready) begin
        chk("beat_accept_timeout", 0, 1);
        bus.id_valid = 1'b0;
        return;
      end
      acc_cyc[i] = cyc;
      @(posedge clk);
      #1;
    end
    bus.id_valid = 1'b0;
    bus.id_last  = 1'b0;
  endtask

  task automatic wait_drained();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("results_drained", exp_q.size(), 0);
  endtask

  task automatic wait_res_valid(output int c);
    int t = 0;
    while (!bus.res_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid_seen", int'(bus.res_valid), 1);
    c = cyc;
  endtask

  // Consumer: drives res_ready per the current backpressure mode
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = ($urandom_range(0, 1) == 1);
        default: bus.res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops and compares every accepted result
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("res_addr",  int'(bus.res_addr),  e.addr);
          chk("res_found", int'(bus.res_found), e.found);
          chk("res_depth", int'(bus.res_depth), e.depth);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int c, r0, len, cur, s, n, p;
    bus.id_valid = 1'b0;
    bus.id_data  = '0;
    bus.id_last  = 1'b0;
    clear_tree();
    load_mem();
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(outs()), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Small tree: root {1,2}, node2 {3}
    add_node(1, 8'h10, 0);
    add_node(2, 8'h20, 0);
    add_node(3, 8'h30, 2);
    load_mem();
    path_buf[0] = 8'h20; path_buf[1] = 8'h30;
    send_path(2);
    chk("slot1_accept_gap", acc_cyc[1] - acc_cyc[0], 4);
    path_buf[0] = 8'h20; path_buf[1] = 8'h55; path_buf[2] = 8'h30;
    send_path(3);
    path_buf[0] = 8'h00;
    send_path(1);
    wait_drained();

    // Full root, match in last slot
    clear_tree();
    for (int i = 1; i <= 4; i++) add_node(i, 8'h10 + i, 0);
    load_mem();
    r0 = rd_cnt;
    path_buf[0] = 8'h14;
    send_path(1);
    wait_res_valid(c);
    chk("full_root_reads", rd_cnt - r0, 5);
    chk("slot3_latency", c - acc_cyc[0], 6);
    path_buf[0] = 8'h99;
    send_path(1);
    wait_drained();

    // Result held under backpressure
    rr_mode = 2;
    path_buf[0] = 8'h12;
    send_path(1);
    wait_res_valid(c);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_stable",
          int'({15'd0, bus.id_ready, bus.mem_rd_en, bus.res_valid, bus.res_addr, bus.res_found, bus.res_depth}),
          int'({15'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 3'd1}));
    end
    rr_mode = 0;
    wait_drained();
    path_buf[0] = 8'h13;
    send_path(1);
    wait_drained();

    // Reset while probing
    path_buf[0] = 8'h14;
    send_path(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_probe", int'(outs()), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    path_buf[0] = 8'h11;
    send_path(1);
    wait_drained();

    // Chain deeper than the hierarchy limit
    clear_tree();
    for (int i = 1; i <= 5; i++) add_node(i, 8'h40 + i, i-1);
    load_mem();
    for (int i = 0; i < 5; i++) path_buf[i] = 8'h41 + i;
    send_path(4);
    send_path(5);
    path_buf[1] = 8'h00;
    send_path(3);
    wait_drained();

    // Random trees and paths with random backpressure
    rr_mode = 1;
    for (int t = 0; t < 10; t++) begin
      wait_drained();
      clear_tree();
      n = int'($urandom_range(3, 24));
      for (int i = 1; i < n; i++) begin
        p = int'($urandom_range(0, i-1));
        if (nkids[p] >= MAXN) p = i-1;
        add_node(i, int'($urandom_range(1, 6)), p);
      end
      load_mem();
      for (int q = 0; q < 12; q++) begin
        len = int'($urandom_range(1, 5));
        cur = 0;
        for (int i = 0; i < len; i++) begin
          if (nkids[cur] > 0 && $urandom_range(0, 3) != 0) begin
            s = int'($urandom_range(0, nkids[cur]-1));
            path_buf[i] = node_id[kids[cur][s]];
            cur = kids[cur][s];
          end else begin
            path_buf[i] = int'($urandom_range(0, 7));
          end
        end
        send_path(len);
      end
    end
    rr_mode = 0;
    wait_drained();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
